prio_rr_arbiter: RTL
====================

PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, number of requesters (N >= 2).
REQ-002 The block SHALL have parameter PW, default 4, priority field width per requester.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, maximum grant length in cycles; 0 = unlimited.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port req  input  N  request vector, bit i = channel i.
REQ-007 The block SHALL have port prt  input  N*PW  packed priorities, channel i at [i*PW +: PW], larger value = higher priority.
REQ-008 The block SHALL have port valid  output  1  grant currently held.
REQ-009 The block SHALL have port grant  output  $clog2(N)  index of granted channel.
REQ-010 The block SHALL have port grant_oh  output  N  one-hot grant; all-zero when valid=0.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and HOLD; valid=1 exactly in HOLD.
REQ-012 In IDLE with req != 0, the block SHALL select a winner and enter HOLD on the next edge; valid, grant and grant_oh are registered, so latency from req to valid is 1 cycle.
REQ-013 The winner SHALL be the requesting channel with the largest prt value; priority 0 is still eligible.
REQ-014 Ties among equal highest priority SHALL go to the first tied channel at or after rr_ptr in circular index order (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
REQ-015 On each grant, rr_ptr SHALL load (winner+1) mod N; rr_ptr SHALL not change otherwise.
REQ-016 In IDLE with req == 0, the block SHALL stay in IDLE; grant holds its last value; grant_oh = 0.
REQ-017 In HOLD, grant and grant_oh SHALL be stable; req and prt changes on other channels SHALL NOT affect them.
REQ-018 In HOLD, hold_cnt SHALL count cycles of the current grant, 0 in the first HOLD cycle, saturating at MAX_HOLD-1.
REQ-019 In HOLD, the block SHALL return to IDLE on the next edge when req[grant]=0 (release).
REQ-020 When MAX_HOLD != 0, the block SHALL return to IDLE on the next edge when hold_cnt = MAX_HOLD-1 (timeout), regardless of req[grant]; a grant therefore lasts at most MAX_HOLD cycles.
REQ-021 Release and timeout in the same cycle SHALL be treated as one exit to IDLE.
REQ-022 Every HOLD->IDLE exit SHALL produce exactly one cycle with valid=0 before any new grant.
REQ-023 A timed-out channel that still requests SHALL be re-eligible in the next arbitration; it wins only by strictly higher priority, or by tie order after rr_ptr advanced.
REQ-024 prt SHALL be sampled only in the IDLE arbitration cycle.
REQ-025 When MAX_HOLD = 0, hold_cnt SHALL not exist or SHALL have no effect; exit is by release only.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL enter IDLE with valid=0, grant=0, grant_oh=0, rr_ptr=0 and hold_cnt=0, including mid-HOLD.
REQ-027 While rst=1, req SHALL be ignored; the first grant after reset SHALL occur no earlier than the cycle after the edge at which rst is first sampled 0, plus 1.

Verification
REQ-028 Default parameters, reset, then req=8'b0010_0100 with prt ch2=5, ch5=9 -> 1 cycle later valid=1, grant=5, grant_oh=8'b0010_0000.
REQ-029 All 8 channels request, all prt=3, each held until dropped after 2 cycles -> grants 0,1,2,...,7,0 in order, with one valid=0 gap between each.
REQ-030 MAX_HOLD=16, ch4 prt=7 held continuously, ch1 prt=7 requesting -> ch4 (or ch1 per rr_ptr) valid exactly 16 cycles, 1 idle cycle, then the other tied channel granted.
REQ-031 During a HOLD of ch3, raise ch6 with prt=15 and change prt[3] -> grant stays 3 until ch3 drops; after 1 idle cycle, grant=6.
REQ-032 Assert rst for 1 cycle mid-HOLD of ch7 -> next cycle valid=0, grant=0, grant_oh=0; a subsequent all-equal tie resolves to ch0 (rr_ptr=0).
REQ-033 N=5, PW=2, MAX_HOLD=0, ch4 requests forever -> grant=4 held indefinitely, no timeout, grant width 3 bits.

Source files
------------

// File: rtl/prio_rr_arbiter.sv
// Priority arbiter with round-robin tie-break among equal-priority requesters.
// A grant is held until its requester drops or, optionally, a maximum hold length expires.
module prio_rr_arbiter #(
  parameter int N        = 8,
  parameter int PW       = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*PW-1:0]      prt,
  output logic                 valid,
  output logic [$clog2(N)-1:0] grant,
  output logic [N-1:0]         grant_oh
);

  localparam int IW = $clog2(N);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [N-1:0]    grant_oh_q, grant_oh_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            rst_dly_q, rst_dly_d;

  logic            found;
  logic [PW-1:0]   best_p;
  logic [IW-1:0]   win;
  logic            timeout;

  // Scan in circular order from rr_ptr; strict '>' keeps the first tied channel.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    best_p = '0;
    win    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx] && (!found || prt[idx*PW +: PW] > best_p)) begin
        found  = 1'b1;
        best_p = prt[idx*PW +: PW];
        win    = IW'(idx);
      end
    end
  end

  assign timeout = (MAX_HOLD != 0) && (hold_cnt_q == CNT_MAX);

  // Keeps arbitration off for the first cycle after reset deasserts.
  assign rst_dly_d = 1'b0;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        grant_oh_d = '0;
        if (!rst_dly_q && found) begin
          state_d         = HOLD;
          grant_d         = win;
          grant_oh_d[win] = 1'b1;
          rr_ptr_d        = (win == IW'(N - 1)) ? '0 : win + 1'b1;
          hold_cnt_d      = '0;
        end
      end
      HOLD: begin
        if (!req[grant_q] || timeout) begin
          state_d    = IDLE;
          grant_oh_d = '0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      rst_dly_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      rst_dly_q  <= rst_dly_d;
    end
  end

  assign valid    = (state_q == HOLD);
  assign grant    = grant_q;
  assign grant_oh = grant_oh_q;

endmodule
